// File: rtl/test_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : test_pattern_gen_if
// Purpose  : Video bus of the test pattern generator (fval/lval + packed pixels).
// Revision : 1.0
// ============================================================================
interface test_pattern_gen_if #(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 1
);
  logic                              o_fval;
  logic                              o_lval;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_pix_data;

  modport master (output o_fval, output o_lval, output ov_pix_data);
  modport slave  (input  o_fval, input  o_lval, input  ov_pix_data);
endinterface
`default_nettype wire

// File: rtl/test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : test_pattern_gen
// Purpose  : Frame/line timed test pattern source; define TEST_PATTERN_RANDOM_EN
//            to drive mode 3 from per-channel LFSRs instead of the pixel ramp.
// Revision : 1.0
// ============================================================================
module test_pattern_gen #(
  parameter int DATA_WIDTH  = 10,
  parameter int CHANNEL_NUM = 1,
  parameter int REG_WD      = 32,
  parameter int LEAD_CYCLES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_acq_start,
  input  logic [15:0]        iv_width,
  input  logic [15:0]        iv_height,
  input  logic [15:0]        iv_h_blank,
  input  logic [15:0]        iv_v_blank,
  input  logic [1:0]         iv_mode,
  test_pattern_gen_if.master vid,
  output logic [REG_WD-1:0]  ov_frame_cnt
);

  localparam logic [15:0] c_chn        = 16'(CHANNEL_NUM);
  localparam logic [15:0] c_lead_last  = 16'(LEAD_CYCLES - 1);
  localparam logic [1:0]  c_mode_line  = 2'd0;
  localparam logic [1:0]  c_mode_frame = 2'd1;
`ifdef TEST_PATTERN_RANDOM_EN
  localparam logic [1:0]  c_mode_rand  = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEAD   = 3'd1,
    S_LINE   = 3'd2,
    S_HBLANK = 3'd3,
    S_TRAIL  = 3'd4,
    S_VBLANK = 3'd5
  } state_t;

  state_t                              state_q, state_d;
  logic [15:0]                         cnt_q, cnt_d;
  logic [15:0]                         beat_q, beat_d;
  logic [15:0]                         line_q, line_d;
  logic [15:0]                         width_q, width_d;
  logic [15:0]                         height_q, height_d;
  logic [15:0]                         hblank_q, hblank_d;
  logic [15:0]                         vblank_q, vblank_d;
  logic [15:0]                         beats_q, beats_d;
  logic [1:0]                          mode_q, mode_d;
  logic [REG_WD-1:0]                   frame_cnt_q, frame_cnt_d;
  logic                                fval_q, fval_d;
  logic                                lval_q, lval_d;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0]   data_q, data_d;
  logic [15:0]                         beats_in;
`ifdef TEST_PATTERN_RANDOM_EN
  logic [15:0]                         lfsr_q [CHANNEL_NUM];
  logic [15:0]                         lfsr_d [CHANNEL_NUM];
`endif

  // Beats per line, rounded up so a partial last beat is still emitted.
  assign beats_in = (iv_width / c_chn) + (((iv_width % c_chn) != 16'd0) ? 16'd1 : 16'd0);

  function automatic logic [DATA_WIDTH-1:0] ramp_pix(
    input logic [1:0]        mode,
    input logic [16:0]       x,
    input logic [15:0]       y,
    input logic [REG_WD-1:0] f
  );
    case (mode)
      c_mode_line:  return DATA_WIDTH'(y);
      c_mode_frame: return DATA_WIDTH'(f);
      default:      return DATA_WIDTH'(x + {1'b0, y});
    endcase
  endfunction

  always_comb begin
    logic [16:0] x;
    x           = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    beat_d      = beat_q;
    line_d      = line_q;
    width_d     = width_q;
    height_d    = height_q;
    hblank_d    = hblank_q;
    vblank_d    = vblank_q;
    beats_d     = beats_q;
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    data_d      = '0;
`ifdef TEST_PATTERN_RANDOM_EN
    lfsr_d      = lfsr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_acq_start && (iv_width >= c_chn) && (iv_height != 16'd0)) begin
          state_d  = S_LEAD;
          cnt_d    = '0;
          width_d  = iv_width;
          height_d = iv_height;
          hblank_d = iv_h_blank;
          vblank_d = iv_v_blank;
          beats_d  = beats_in;
          mode_d   = iv_mode;
        end
      end
      S_LEAD: begin
        if (cnt_q == c_lead_last) begin
          state_d = S_LINE;
          cnt_d   = '0;
          beat_d  = '0;
          line_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LINE: begin
        if (beat_q == beats_q - 16'd1) begin
          if (line_q == height_q - 16'd1) begin
            state_d = S_TRAIL;
            cnt_d   = '0;
          end else if (hblank_q == 16'd0) begin
            beat_d = '0;
            line_d = line_q + 16'd1;
          end else begin
            state_d = S_HBLANK;
            cnt_d   = '0;
          end
        end else begin
          beat_d = beat_q + 16'd1;
        end
      end
      S_HBLANK: begin
        if (cnt_q == hblank_q - 16'd1) begin
          state_d = S_LINE;
          cnt_d   = '0;
          beat_d  = '0;
          line_d  = line_q + 16'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_TRAIL: begin
        if (cnt_q == c_lead_last) begin
          // fval falls on this edge, so the frame is counted here.
          frame_cnt_d = frame_cnt_q + REG_WD'(1);
          state_d     = (vblank_q == 16'd0) ? S_IDLE : S_VBLANK;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VBLANK: begin
        if (cnt_q == vblank_q - 16'd1) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    fval_d = (state_d != S_IDLE) && (state_d != S_VBLANK);
    lval_d = (state_d == S_LINE);

    // Pixel data is computed from the next beat so it lands with lval.
    if (lval_d) begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        x = 17'(beat_d) * 17'(CHANNEL_NUM) + 17'(c);
        if (x < {1'b0, width_q}) begin
`ifdef TEST_PATTERN_RANDOM_EN
          if (mode_q == c_mode_rand) begin
            data_d[c*DATA_WIDTH +: DATA_WIDTH] = lfsr_q[c][DATA_WIDTH-1:0];
          end else begin
            data_d[c*DATA_WIDTH +: DATA_WIDTH] = ramp_pix(mode_q, x, line_d, frame_cnt_q);
          end
`else
          data_d[c*DATA_WIDTH +: DATA_WIDTH] = ramp_pix(mode_q, x, line_d, frame_cnt_q);
`endif
        end
`ifdef TEST_PATTERN_RANDOM_EN
        if (mode_q == c_mode_rand) begin
          lfsr_d[c] = {lfsr_q[c][14:0], lfsr_q[c][15] ^ lfsr_q[c][13] ^ lfsr_q[c][12] ^ lfsr_q[c][10]};
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      line_q      <= '0;
      width_q     <= '0;
      height_q    <= '0;
      hblank_q    <= '0;
      vblank_q    <= '0;
      beats_q     <= '0;
      mode_q      <= '0;
      frame_cnt_q <= '0;
      fval_q      <= 1'b0;
      lval_q      <= 1'b0;
      data_q      <= '0;
`ifdef TEST_PATTERN_RANDOM_EN
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        lfsr_q[c] <= 16'(c + 1);
      end
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      width_q     <= width_d;
      height_q    <= height_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      beats_q     <= beats_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      fval_q      <= fval_d;
      lval_q      <= lval_d;
      data_q      <= data_d;
`ifdef TEST_PATTERN_RANDOM_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign vid.o_fval      = fval_q;
  assign vid.o_lval      = lval_q;
  assign vid.ov_pix_data = data_q;
  assign ov_frame_cnt    = frame_cnt_q;

endmodule
`default_nettype wire
